// File: rtl/vnlp.sv
// vnlp: walks a circular linked list of 2-D floating-point vectors held in an
// internal preloaded memory and accumulates the squared norm X^2+Y^2 of every
// visited node. NORM2 = {39-bit normalised fraction mantissa, 8-bit exponent}.

module vnlp_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [23:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_data
);
   logic [23:0] memory [0:DEPTH-1];

   // Single-port style block RAM with registered read (1-cycle latency).
   always_ff @(posedge clk) begin
      if (wr_en) memory[wr_addr] <= wr_data;
      rd_data <= memory[rd_addr];
   end
endmodule

module vnlp #(
   parameter int DEPTH   = 64,
   parameter int HEAD    = 0,
   parameter int MAX_LEN = 127
) (
   output logic        DONE,
   output logic [46:0] NORM2,
   output logic [6:0]  LEN,
   input  logic        START,
   input  logic        clk,
   input  logic        rst_n
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] HEAD_FWD  = AW'(HEAD + 1);
   localparam logic [23:0]   HEAD_PTR  = 24'(HEAD + 1);
   localparam logic [24:0]   DEPTH_W   = 25'(DEPTH);
   localparam logic [6:0]    MAX_LEN_W = 7'(MAX_LEN);
   localparam logic [AW-1:0] ONE       = AW'(1);
   localparam logic [AW-1:0] TWO       = AW'(2);

   typedef enum logic [2:0] {
      ST_IDLE, ST_READ_PTR, ST_READ_X, ST_READ_Y, ST_ACCUM, ST_NEXT, ST_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] cur_reg, cur_next;
   logic [22:0]   x_reg, x_next, y_reg, y_next;
   logic [23:0]   ptr_reg, ptr_next;
   logic [38:0]   acc_m_reg, acc_m_next;
   logic [7:0]    acc_e_reg, acc_e_next;
   logic [6:0]    len_reg, len_next;
   logic          done_reg, done_next;
   logic          armed_reg, armed_next;

   logic [AW-1:0] rd_addr;
   logic [23:0]   rd_data;

   // Memory is filled by preload only; the write port stays idle.
   vnlp_mem #(.DEPTH(DEPTH), .AW(AW)) M2_MEM (
      .clk(clk), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(1'b0), .wr_addr('0), .wr_data(24'd0)
   );

   // Squarer + floating accumulate: X^2 during ACCUM, Y^2 during READ_PTR.
   logic [22:0]       sq_src;
   logic [29:0]       sq_p;
   logic [38:0]       ma, mb, m_norm, m_shift, add_m;
   logic signed [9:0] ea, eb, e_sum, e_n, e_shift;
   logic [9:0]        diff;
   logic [39:0]       m_sum;
   logic [5:0]        lz;
   logic [7:0]        add_e;

   always_comb begin
      sq_src  = (state_reg == ST_ACCUM) ? x_reg : y_reg;
      sq_p    = sq_src[22:8] * sq_src[22:8];
      mb      = {sq_p, 9'd0};
      eb      = {sq_src[7], sq_src[7:0], 1'b0};
      ma      = acc_m_reg;
      ea      = {{2{acc_e_reg[7]}}, acc_e_reg};
      diff    = 10'd0;
      m_sum   = 40'd0;
      e_sum   = 10'sd0;
      // zero operands bypass alignment so their exponent never matters
      if (ma == 39'd0) begin
         m_sum = {1'b0, mb};
         e_sum = eb;
      end else if (mb == 39'd0) begin
         m_sum = {1'b0, ma};
         e_sum = ea;
      end else if (ea >= eb) begin
         diff  = ea - eb;
         m_sum = {1'b0, ma} + {1'b0, (diff >= 10'd39) ? 39'd0 : (mb >> diff)};
         e_sum = ea;
      end else begin
         diff  = eb - ea;
         m_sum = {1'b0, mb} + {1'b0, (diff >= 10'd39) ? 39'd0 : (ma >> diff)};
         e_sum = eb;
      end
      if (m_sum[39]) begin
         m_norm = m_sum[39:1];
         e_n    = e_sum + 10'sd1;
      end else begin
         m_norm = m_sum[38:0];
         e_n    = e_sum;
      end
      lz = 6'd0;
      for (int i = 0; i < 39; i++) begin
         if (m_norm[i]) lz = 6'(38 - i);
      end
      m_shift = m_norm << lz;
      e_shift = e_n - $signed({4'd0, lz});
      add_m   = m_shift;
      add_e   = e_shift[7:0];
      if (m_norm == 39'd0) begin
         add_m = 39'd0;
         add_e = 8'd0;
      end else if (e_shift > 10'sd127) begin
         add_m = '1;                 // overflow saturates
         add_e = 8'h7F;
      end else if (e_shift < -10'sd128) begin
         add_m = 39'd0;              // underflow flushes to zero
         add_e = 8'd0;
      end
   end

   // Read address: X, Y, then the forward pointer of the current node.
   always_comb begin
      rd_addr = cur_reg;
      case (state_reg)
         ST_READ_X: rd_addr = cur_reg + ONE;
         ST_READ_Y: rd_addr = cur_reg + TWO;
         default:   rd_addr = cur_reg;
      endcase
   end

   // Next-state and datapath updates of the list walker.
   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      ptr_next   = ptr_reg;
      acc_m_next = acc_m_reg;
      acc_e_next = acc_e_reg;
      len_next   = len_reg;
      done_next  = done_reg;
      armed_next = armed_reg | ~START;
      case (state_reg)
         ST_IDLE: begin
            if (START && armed_reg) begin
               done_next  = 1'b0;
               acc_m_next = 39'd0;
               acc_e_next = 8'd0;
               len_next   = 7'd0;
               cur_next   = HEAD_FWD;
               state_next = ST_READ_X;
            end
         end
         ST_READ_X: state_next = ST_READ_Y;
         ST_READ_Y: begin
            x_next     = rd_data[22:0];
            state_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            y_next     = rd_data[22:0];
            acc_m_next = add_m;
            acc_e_next = add_e;
            len_next   = len_reg + 7'd1;
            state_next = ST_READ_PTR;
         end
         ST_READ_PTR: begin
            ptr_next   = rd_data;
            acc_m_next = add_m;
            acc_e_next = add_e;
            state_next = ST_NEXT;
         end
         ST_NEXT: begin
            if (ptr_reg == HEAD_PTR || ({1'b0, ptr_reg} + 25'd2) >= DEPTH_W ||
                len_reg == MAX_LEN_W) begin
               done_next  = 1'b1;
               armed_next = 1'b0;    // START must drop before another run
               state_next = ST_DONE;
            end else begin
               cur_next   = ptr_reg[AW-1:0];
               state_next = ST_READ_X;
            end
         end
         ST_DONE: begin
            if (!START) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers; memory contents are not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cur_reg   <= '0;
         x_reg     <= 23'd0;
         y_reg     <= 23'd0;
         ptr_reg   <= 24'd0;
         acc_m_reg <= 39'd0;
         acc_e_reg <= 8'd0;
         len_reg   <= 7'd0;
         done_reg  <= 1'b0;
         armed_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         ptr_reg   <= ptr_next;
         acc_m_reg <= acc_m_next;
         acc_e_reg <= acc_e_next;
         len_reg   <= len_next;
         done_reg  <= done_next;
         armed_reg <= armed_next;
      end
   end

   assign DONE  = done_reg;
   assign NORM2 = {acc_m_reg, acc_e_reg};
   assign LEN   = len_reg;
endmodule

// File: tb/tb_vnlp.sv
// Directed bench for vnlp: preloads the 8-node ring and variants, runs the
// walker and compares LEN/NORM2/DONE against hand-computed values.

module tb_vnlp;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        done;
   logic [46:0] norm2;
   logic [6:0]  len;

   int checks = 0;
   int errors = 0;

   localparam logic [46:0] NORM_RING = {39'd61803639 << 13, 8'd16};
   localparam logic [46:0] NORM_OOB  = {39'd322893 << 20, 8'd14};
   localparam logic [46:0] NORM_SELF = {39'd106325 << 22, 8'd11};
   localparam logic [46:0] NORM_ZERO = {39'd59730413 << 13, 8'd16};
   localparam logic [46:0] NORM_MAX  = {39'd68078411 << 12, 8'd21};
   localparam logic [46:0] NORM_SAT  = {39'h7F_FFFF_FFFF, 8'h7F};

   vnlp dut (
      .DONE(done), .NORM2(norm2), .LEN(len),
      .START(start), .clk(clk), .rst_n(rst_n)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // value given in 1/32 units; nrm selects a normalised mantissa
   function automatic logic [23:0] enc(input int v32, input bit nrm);
      logic [14:0] m;
      logic [7:0]  e;
      int          k;
      k = (v32 < 0) ? -v32 : v32;
      m = 15'(k * 8);
      e = 8'd7;
      if (nrm && m != 15'd0) begin
         while (!m[14]) begin
            m = m << 1;
            e = e - 8'd1;
         end
      end
      return {(v32 < 0), m, e};
   endfunction

   task automatic load_node(input int b, input int back, input int fwd,
                            input int x32, input int y32, input bit nrm);
      dut.M2_MEM.memory[b]     = 24'(back);
      dut.M2_MEM.memory[b + 1] = 24'(fwd);
      dut.M2_MEM.memory[b + 2] = enc(x32, nrm);
      dut.M2_MEM.memory[b + 3] = enc(y32, !nrm);
   endtask

   task automatic preload_ring();
      for (int i = 0; i < 64; i++) dut.M2_MEM.memory[i] = 24'd0;
      load_node(0,  49, 34, -1060, 760,   1'b1);
      load_node(33, 0,  23, 824,   2820,  1'b0);
      load_node(22, 33, 12, 1001,  1035,  1'b1);
      load_node(11, 22, 18, 816,   -2980, 1'b0);
      load_node(17, 11, 6,  260,   2883,  1'b1);
      load_node(5,  17, 40, 609,   3264,  1'b0);
      load_node(39, 5,  50, 1811,  1557,  1'b1);
      load_node(49, 39, 1,  3263,  2024,  1'b0);
      load_node(28, 0,  240, 320,  320,   1'b1);
      load_node(44, 0,  29, 640,   -640,  1'b0);
   endtask

   // START must already be high; waits for DONE within 8*LEN+4 cycles
   task automatic run_wait(input string tag, input int elen, input logic [46:0] enorm);
      int cyc;
      @(posedge clk); #1;
      check_val({tag, "_busy_done"}, done, 0);
      check_val({tag, "_busy_len"}, len, 0);
      cyc = 1;
      while (!done && cyc < 8 * elen + 4) begin
         @(posedge clk); #1;
         cyc++;
      end
      $display("run %s: done=%0d len=%0d norm2=%h cycles=%0d", tag, done, len, norm2, cyc);
      check_val({tag, "_done"}, done, 1);
      check_val({tag, "_len"}, len, elen);
      check_val({tag, "_norm2"}, norm2, enorm);
   endtask

   task automatic rearm_and_preload();
      start = 1'b0;
      @(posedge clk); #1;
      preload_ring();
   endtask

   initial begin
      bit dropped;
      clk   = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
      preload_ring();
      #2 rst_n = 1'b0;
      #2;
      check_val("reset_done", done, 0);
      check_val("reset_len", len, 0);
      check_val("reset_norm2", norm2, 0);
      #4 rst_n = 1'b1;
      #3 start = 1'b1;
      run_wait("ring", 8, NORM_RING);

      // START held high after DONE must not restart
      dropped = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if (!done || len != 7'd8 || norm2 != NORM_RING) dropped = 1'b1;
      end
      $display("run hold: done=%0d len=%0d norm2=%h", done, len, norm2);
      check_val("hold_stable", dropped, 0);
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      run_wait("restart", 8, NORM_RING);

      // asynchronous reset in the middle of a run
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("run midreset: done=%0d len=%0d norm2=%h", done, len, norm2);
      check_val("midrst_done", done, 0);
      check_val("midrst_len", len, 0);
      check_val("midrst_norm2", norm2, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_wait("after_reset", 8, NORM_RING);

      rearm_and_preload();
      dut.M2_MEM.memory[34] = 24'd102;
      start = 1'b1;
      run_wait("out_of_range", 2, NORM_OOB);

      rearm_and_preload();
      dut.M2_MEM.memory[1] = 24'd1;
      start = 1'b1;
      run_wait("self_loop", 1, NORM_SELF);

      rearm_and_preload();
      dut.M2_MEM.memory[1] = 24'd1;
      dut.M2_MEM.memory[2] = {1'b0, 15'h4000, 8'd100};
      start = 1'b1;
      run_wait("saturate", 1, NORM_SAT);

      rearm_and_preload();
      dut.M2_MEM.memory[24] = {1'b0, 15'd0, 8'h55};
      dut.M2_MEM.memory[25] = {1'b1, 15'd0, 8'hA3};
      start = 1'b1;
      run_wait("zero_node", 8, NORM_ZERO);

      rearm_and_preload();
      dut.M2_MEM.memory[34] = 24'd34;
      start = 1'b1;
      run_wait("max_len", 127, NORM_MAX);

      start = 1'b0;
      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vnlp.md
Name: vnlp

Overview:
- Linked-list vector-norm processor.
- On START it walks a circular linked list of 2-D vectors held in its internal preloaded memory, starting at the head node. It accumulates the squared Euclidean norm X²+Y² of every visited node and counts the nodes.
- It reports NORM2 and LEN with a DONE flag.
- It is a standalone compute block; list contents are placed in memory before START by preload (hierarchical write into the memory array).

Parameters:
- DEPTH, 64, number of 24-bit memory words (addresses 0..63).
- HEAD, 0, base address of the head node.
- MAX_LEN, 127, hard cap on nodes visited.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- DONE  output  1  result valid, held until next run.
- NORM2  output  47  sum of squares; [46:8] unsigned fraction mantissa, [7:0] exponent.
- LEN  output  7  number of nodes accumulated.
- START  input  1  level request to run.
- Positional order for instantiation: DONE, NORM2, LEN, START, clk, rst_n.

Behaviour:
- Memory:
  - Internal instance M2_MEM containing array `memory[0:DEPTH-1]` of 24 bits.
  - No external write port; not cleared by reset.
  - Synchronous read, 1-cycle latency.
- Node at base b:
  - mem[b] = back pointer (ignored).
  - mem[b+1] = forward pointer F, which holds the address of the next node's forward field (next base + 1).
  - mem[b+2] = X, mem[b+3] = Y.
- Number format (24 bits): [23] sign, [22:8] 15-bit fraction M, [7:0] two's-complement exponent E.
  - Value = (-1)^s × 0.M × 2^E. Example: 1_100001001000000_00000110 = -33.125.
  - M=0 means zero, regardless of E.
- Square: mantissa M×M (30 bits exact), exponent 2E, sign dropped.
- Accumulate: align the smaller operand by right shift (truncate toward zero), add, renormalise so that NORM2[46]=1 unless the result is 0.
  - Results representable in 39 bits are exact.
  - On exponent overflow, saturate: mantissa all ones, exponent 0x7F.
- States: IDLE, READ_PTR, READ_X, READ_Y, ACCUM, NEXT, DONE.
- Run start: in IDLE with START=1 and START having been 0 since the last DONE:
  - DONE←0, NORM2←0, LEN←0, cur←HEAD+1.
- Per node:
  - Read X at cur+1 and Y at cur+2; add X²+Y² to the accumulator; LEN+1.
  - Read next=mem[cur].
  - Stop if next==HEAD+1 (back at head), or next+2 ≥ DEPTH (including any nonzero bits [23:6]), or LEN==MAX_LEN.
  - Otherwise cur←next.
- Latency: ≤8 cycles per node; DONE rises ≤8×LEN+4 cycles after START is sampled.
- DONE state: DONE=1; NORM2 and LEN stable.
  - START held high does not restart.
  - START low for ≥1 cycle, then high, starts a new run.
- Reset (asynchronous, any time including mid-run): DONE=0, NORM2=0, LEN=0, state IDLE, memory untouched.
  - After reset a high START starts a run (START-low history cleared).
- The head node is always accumulated (LEN≥1 per run).

Test Plan:
- Preload 8-node ring. Layout as base:(back,fwd,X,Y):
  - 0:(49,34,-33.125,23.75)
  - 33:(0,23,25.75,88.125)
  - 22:(33,12,31.28125,32.34375)
  - 11:(22,18,25.5,-93.125)
  - 17:(11,6,8.125,90.09375)
  - 5:(17,40,19.03125,102.0)
  - 39:(5,50,56.59375,48.65625)
  - 49:(39,1,101.96875,63.25)
  - Plus unlinked nodes at 28 (fwd 240) and 44.
  - START at 11 ns, clk period 10 ns → DONE=1, LEN=8, NORM2 = 60355.1162109375 (mantissa 61803639<<13, exponent 16). Unlinked nodes are not counted.
- Same preload but mem[34]=102 (out of range) → LEN=2, NORM2=10090.40625 (exponent 14).
- mem[1]=1 (head self-loop) → LEN=1, NORM2=1661.328125 (exponent 11).
- Assert rst_n=0 mid-run → outputs 0 immediately. Release with START high → fresh run gives the full-ring result again.
- After DONE, keep START high 50 cycles → no restart, outputs constant. Then START 0→1 → identical result.
- Node with X=Y=0 in ring → LEN counts it; NORM2 unchanged.
